// File: rtl/rr_mux_arbiter_if.sv
// Handshake bundle between the 4-to-1 mux requesters and the round-robin arbiter.
// Ports: req[3:0] and release_i come from the requesters. sel, grant, busy and timeout go back to them.
// The master modport is the requester side. The slave modport is the arbiter side.
interface rr_mux_arbiter_if;
  logic [3:0] req;
  logic       release_i;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       busy;
  logic       timeout;

  modport master (
    output req,
    output release_i,
    input  sel,
    input  grant,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  release_i,
    output sel,
    output grant,
    output busy,
    output timeout
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that drives the select code of a 4-to-1 mux stage.
// Ports: clk, rst_n (async active-low), bus (slave side of rr_mux_arbiter_if).
// Latency: a request is granted 1 cycle after it is sampled, and one IDLE cycle separates grants.
// Backpressure: requests are ignored while a grant is active. A grant lasts at most MAX_HOLD cycles.
module rr_mux_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  rr_mux_arbiter_if.slave   bus
);

  localparam int unsigned    CNT_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       sel_q;
  logic [3:0]       grant_q;
  logic             busy_q;
  logic             timeout_q;

  logic [1:0]       winner;
  logic             end_rel;
  logic             end_drop;
  logic             end_lim;

  // Scan from ptr upward (mod 4). Iterating from the farthest offset down
  // means the closest set request is the last one assigned, so it wins.
  always_comb begin
    winner = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[ptr + 2'(k)]) begin
        winner = ptr + 2'(k);
      end
    end
  end

  assign end_rel  = bus.release_i;
  assign end_drop = ~bus.req[sel_q];
  assign end_lim  = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      cnt       <= '0;
      sel_q     <= 2'd0;
      grant_q   <= 4'b0000;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          // sel keeps its last value while idle. Only entry to GRANT moves it.
          if (|bus.req) begin
            sel_q   <= winner;
            grant_q <= 4'b0001 << winner;
            busy_q  <= 1'b1;
            cnt     <= '0;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (end_rel || end_drop || end_lim) begin
            state     <= IDLE;
            grant_q   <= 4'b0000;
            busy_q    <= 1'b0;
            ptr       <= sel_q + 2'd1;
            // Flag a timeout only when the hold limit alone ended the grant.
            timeout_q <= end_lim && !end_rel && !end_drop;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sel     = sel_q;
  assign bus.grant   = grant_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter that generates the select code for the 4-to-1 multiplexer stage. It accepts four request lines, grants exactly one requester at a time, and drives `sel[1:0]` to route that requester's `w[i]` bit to `y`. It holds each grant until the owner releases it, the owner drops its request, or a hold limit expires. After every grant, priority rotates so no requester starves.

## Interface

Parameters:
- `MAX_HOLD`, default 8: maximum number of cycles a grant may last (legal range 2..255); counter width is `$clog2(MAX_HOLD)`.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req`  input  4  request line per mux input; `req[i]` asks for `w[i]`.
- `release_i`  input  1  current owner finished; sampled only in GRANT.
- `sel`  output  2  select code to the mux (registered).
- `grant`  output  4  one-hot grant, registered; `grant[i]=1` iff `sel==i` and busy.
- `busy`  output  1  a grant is active.
- `timeout`  output  1  one-cycle pulse when a grant is ended by the hold limit.

## Operation

- Internal state:
  - FSM {IDLE, GRANT};
  - rotating priority pointer `ptr[1:0]`;
  - hold counter `cnt`.
- IDLE:
  - If `req==0`, stay in IDLE; `sel` keeps its last value, `grant=0`, `busy=0`.
  - If any `req` is set, the winner is the first set bit scanning `ptr, ptr+1, ptr+2, ptr+3` (mod 4).
  - Next cycle: `sel=winner`, `grant=1<<winner`, `busy=1`, `cnt=0`, state=GRANT.
- GRANT:
  - `sel` and `grant` stay stable; `cnt` increments each cycle.
  - The grant ends at the first edge where any of the following hold:
    - (a) `release_i=1`;
    - (b) `req[sel]=0`;
    - (c) `cnt==MAX_HOLD-1`.
  - On ending: state=IDLE, `grant=0`, `busy=0`, `ptr=sel+1` (mod 4, wraps 3->0).
  - `timeout=1` for one cycle only when (c) is the sole cause. If (a) or (b) coincide with (c), `timeout` stays 0.
- New requests arriving during GRANT are ignored until the return to IDLE.
- `release_i` in IDLE is ignored.
- Grant duration in GRANT is 1..`MAX_HOLD` cycles.

## Timing

- Reset (async assert, sync-style deassert at next edge): `sel=2'b00`, `grant=4'b0000`, `busy=0`, `timeout=0`, `ptr=0`, `cnt=0`, state=IDLE.
- Assertion of `rst_n=0` mid-grant drops `grant`/`busy` immediately, without waiting for a clock edge.
- Request-to-grant latency: 1 cycle. A `req` sampled at edge N produces `grant`/`sel` valid after edge N.
- There is a mandatory one-cycle IDLE bubble between consecutive grants, including back-to-back requests from the same or another requester.
- `timeout` is asserted in the same cycle that `busy` falls.
- `sel` changes only on entry to GRANT. Downstream mux output `y` is valid for the owner throughout `busy=1`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

- Reset: hold `rst_n=0` with `req=4'b1111` -> `sel=0`, `grant=0`, `busy=0`, `timeout=0`. Assert reset mid-GRANT -> `grant` clears without a clock edge.
- Single requester: `req=4'b0100` one cycle after reset -> next cycle `sel=2`, `grant=4'b0100`, `busy=1`. Pulse `release_i` -> `busy=0`, then `ptr=3`.
- Rotation: `req=4'b1111` held with `release_i` pulsed each grant -> grant order 0,1,2,3,0, each separated by one IDLE cycle.
- Wrap and skip: `ptr=3`, `req=4'b0011` -> `sel=0`. Next grant (after release) `sel=1`.
- Timeout: `MAX_HOLD=8`, `req=4'b0010` held, no release -> `busy` high exactly 8 cycles, `timeout` pulses once as `busy` falls. Regrant of `sel=1` follows after one IDLE cycle.
- Simultaneous causes: `release_i=1` at `cnt==MAX_HOLD-1` -> grant ends with `timeout=0`. Owner drops `req` -> grant ends the next edge.
